// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IFU/LSU request, response and memory port bundle
interface mem_port_arbiter_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt;
  logic        ifu_rvld;
  logic [31:0] ifu_rdata;
  logic        lsu_mem_en;
  logic [3:0]  lsu_mem_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_gnt;
  logic        lsu_mem_rvld;
  logic [31:0] lsu_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvld;
  logic [31:0] mem_rdata;
  logic        err_timeout;

  modport slave (
    input  ifu_req, ifu_addr, lsu_mem_en, lsu_mem_wen, lsu_addr, lsu_wdata,
           mem_rvld, mem_rdata,
    output ifu_gnt, ifu_rvld, ifu_rdata, lsu_gnt, lsu_mem_rvld, lsu_rdata,
           mem_en, mem_wen, mem_addr, mem_wdata, err_timeout
  );

  modport master (
    output ifu_req, ifu_addr, lsu_mem_en, lsu_mem_wen, lsu_addr, lsu_wdata,
           mem_rvld, mem_rdata,
    input  ifu_gnt, ifu_rvld, ifu_rdata, lsu_gnt, lsu_mem_rvld, lsu_rdata,
           mem_en, mem_wen, mem_addr, mem_wdata, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IFU and LSU, one outstanding read
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              CLK,
  input  logic              RSTN,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;
  localparam logic [SW-1:0] STARVE_LIM  = SW'(STARVE_MAX);
  localparam logic [7:0]    TIMEOUT_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_starve_cnt;
  logic [7:0]    r_wait_cnt;
  logic          r_err_timeout;

  logic w_idle;
  logic w_busy;
  logic w_ifu_win;
  logic w_lsu_win;
  logic w_lsu_wr;
  logic w_timeout;
  logic w_done;

  // RSTN gates both qualifiers so every combinational output is masked during reset
  assign w_idle    = RSTN && (r_state == IDLE);
  assign w_busy    = RSTN && (r_state != IDLE);
  assign w_ifu_win = w_idle && bus.ifu_req && (!bus.lsu_mem_en || (r_starve_cnt == STARVE_LIM));
  assign w_lsu_win = w_idle && bus.lsu_mem_en && !w_ifu_win;
  assign w_lsu_wr  = |bus.lsu_mem_wen;
  assign w_timeout = w_busy && !bus.mem_rvld && (r_wait_cnt == TIMEOUT_LIM);
  assign w_done    = w_busy && (bus.mem_rvld || w_timeout);

  assign bus.ifu_gnt   = w_ifu_win;
  assign bus.lsu_gnt   = w_lsu_win;
  assign bus.mem_en    = w_ifu_win || w_lsu_win;
  assign bus.mem_wen   = w_lsu_win ? bus.lsu_mem_wen : 4'b0000;
  assign bus.mem_addr  = w_ifu_win ? bus.ifu_addr : (w_lsu_win ? bus.lsu_addr : 32'd0);
  assign bus.mem_wdata = w_lsu_win ? bus.lsu_wdata : 32'd0;

  // A timed-out read returns zero data rather than whatever sits on mem_rdata
  assign bus.ifu_rvld     = w_done && (r_state == RD_IFU);
  assign bus.lsu_mem_rvld = w_done && (r_state == RD_LSU);
  assign bus.ifu_rdata    = (bus.ifu_rvld && bus.mem_rvld) ? bus.mem_rdata : 32'd0;
  assign bus.lsu_rdata    = (bus.lsu_mem_rvld && bus.mem_rvld) ? bus.mem_rdata : 32'd0;
  assign bus.err_timeout  = r_err_timeout;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state       <= IDLE;
      r_starve_cnt  <= '0;
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ifu_win) begin
            r_state      <= RD_IFU;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
          end else if (w_lsu_win) begin
            if (bus.ifu_req && (r_starve_cnt != STARVE_LIM))
              r_starve_cnt <= r_starve_cnt + SW'(1);
            // Writes complete in the grant cycle and leave nothing outstanding
            if (!w_lsu_wr) begin
              r_state    <= RD_LSU;
              r_wait_cnt <= '0;
            end
          end
        end
        default: begin
          if (r_wait_cnt != 8'hFF)
            r_wait_cnt <= r_wait_cnt + 8'd1;
          if (w_timeout)
            r_err_timeout <= 1'b1;
          if (w_done)
            r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic CLK;
  logic RSTN;
  int   total;
  int   bad;

  mem_port_arbiter_if b ();

  mem_port_arbiter #(.STARVE_MAX(3), .TIMEOUT(15)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (b.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        len;
    logic [3:0]  wen;
    logic [31:0] laddr;
    logic [31:0] wdata;
    logic        stray;
    logic [31:0] rdata;
    int          lat;
    logic        e_ig;
    logic        e_lg;
    logic        e_en;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic eig, input logic elg, input logic een,
                         input logic [3:0] ewen, input logic [31:0] eaddr, input logic [31:0] ewdata);
    chk({tag, ".ifu_gnt"}, 32'(b.ifu_gnt), 32'(eig));
    chk({tag, ".lsu_gnt"}, 32'(b.lsu_gnt), 32'(elg));
    chk({tag, ".mem_en"}, 32'(b.mem_en), 32'(een));
    chk({tag, ".mem_wen"}, 32'(b.mem_wen), 32'(ewen));
    chk({tag, ".mem_addr"}, b.mem_addr, eaddr);
    chk({tag, ".mem_wdata"}, b.mem_wdata, ewdata);
  endtask

  task automatic chk_rd(input string tag, input logic eirv, input logic [31:0] eird,
                        input logic elrv, input logic [31:0] elrd);
    chk({tag, ".ifu_rvld"}, 32'(b.ifu_rvld), 32'(eirv));
    chk({tag, ".ifu_rdata"}, b.ifu_rdata, eird);
    chk({tag, ".lsu_rvld"}, 32'(b.lsu_mem_rvld), 32'(elrv));
    chk({tag, ".lsu_rdata"}, b.lsu_rdata, elrd);
  endtask

  task automatic idle_in();
    b.ifu_req     = 1'b0;
    b.ifu_addr    = 32'd0;
    b.lsu_mem_en  = 1'b0;
    b.lsu_mem_wen = 4'd0;
    b.lsu_addr    = 32'd0;
    b.lsu_wdata   = 32'd0;
    b.mem_rvld    = 1'b0;
    b.mem_rdata   = 32'd0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    //          ireq iaddr        len wen    laddr        wdata          str rdata          lat ig lg en wen    addr         wdata
    vt[0] = '{1'b0, 32'h0,     1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 32'h5,        0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0};
    vt[1] = '{1'b1, 32'h100,   1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 32'hDEADBEEF, 2, 1'b1, 1'b0, 1'b1, 4'h0, 32'h100, 32'h0};
    vt[2] = '{1'b0, 32'h0,     1'b1, 4'h0, 32'h200, 32'h77,       1'b0, 32'h11111111, 1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h200, 32'h77};
    vt[3] = '{1'b0, 32'h0,     1'b1, 4'hF, 32'h300, 32'hAAAA5555, 1'b0, 32'h0,        0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h300, 32'hAAAA5555};
    vt[4] = '{1'b1, 32'h104,   1'b1, 4'h3, 32'h304, 32'h1234,     1'b0, 32'h0,        0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h304, 32'h1234};
    vt[5] = '{1'b1, 32'h104,   1'b1, 4'h0, 32'h308, 32'h0,        1'b0, 32'h22222222, 3, 1'b0, 1'b1, 1'b1, 4'h0, 32'h308, 32'h0};
    vt[6] = '{1'b1, 32'h104,   1'b1, 4'h8, 32'h30C, 32'hFF000000, 1'b0, 32'h0,        0, 1'b0, 1'b1, 1'b1, 4'h8, 32'h30C, 32'hFF000000};
    vt[7] = '{1'b1, 32'h108,   1'b1, 4'h0, 32'h310, 32'h0,        1'b0, 32'hCAFEF00D, 1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h108, 32'h0};
    vt[8] = '{1'b1, 32'h10C,   1'b1, 4'h0, 32'h314, 32'h9,        1'b0, 32'h33333333, 1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h314, 32'h9};
    vt[9] = '{1'b1, 32'h110,   1'b0, 4'h5, 32'h318, 32'h99,       1'b0, 32'h44444444, 1, 1'b1, 1'b0, 1'b1, 4'h0, 32'h110, 32'h0};

    idle_in();
    RSTN = 1'b0;
    b.ifu_req    = 1'b1;
    b.ifu_addr   = 32'h40;
    b.lsu_mem_en = 1'b1;
    b.lsu_addr   = 32'h80;
    #12;
    chk_bus("reset", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("reset.err_timeout", 32'(b.err_timeout), 32'h0);
    idle_in();
    @(negedge CLK);
    RSTN = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      b.ifu_req     = v.ireq;
      b.ifu_addr    = v.iaddr;
      b.lsu_mem_en  = v.len;
      b.lsu_mem_wen = v.wen;
      b.lsu_addr    = v.laddr;
      b.lsu_wdata   = v.wdata;
      b.mem_rvld    = v.stray;
      b.mem_rdata   = v.rdata;
      @(negedge CLK);
      chk_bus($sformatf("v%0d", i), v.e_ig, v.e_lg, v.e_en, v.e_wen, v.e_addr, v.e_wdata);
      chk_rd($sformatf("v%0d", i), 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      idle_in();
      for (int k = 1; k <= v.lat; k++) begin
        b.ifu_req    = 1'b1;
        b.ifu_addr   = 32'hF00;
        b.lsu_mem_en = 1'b1;
        b.lsu_addr   = 32'hF04;
        b.mem_rvld   = (k == v.lat);
        b.mem_rdata  = v.rdata;
        @(negedge CLK);
        chk_bus($sformatf("v%0d.wait%0d", i, k), 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk_rd($sformatf("v%0d.ret%0d", i, k),
               v.e_ig && (k == v.lat), (v.e_ig && (k == v.lat)) ? v.rdata : 32'h0,
               v.e_lg && (k == v.lat), (v.e_lg && (k == v.lat)) ? v.rdata : 32'h0);
        step();
      end
      idle_in();
    end

    // LSU held against a waiting IFU: three LSU grants, then the IFU, twice over
    b.ifu_req    = 1'b1;
    b.ifu_addr   = 32'h200;
    b.lsu_mem_en = 1'b1;
    b.lsu_addr   = 32'h400;
    for (int g = 0; g < 8; g++) begin
      logic ei;
      ei = ((g % 4) == 3);
      @(negedge CLK);
      chk($sformatf("starve%0d.ifu_gnt", g), 32'(b.ifu_gnt), 32'(ei));
      chk($sformatf("starve%0d.lsu_gnt", g), 32'(b.lsu_gnt), 32'(!ei));
      chk($sformatf("starve%0d.mem_addr", g), b.mem_addr, ei ? 32'h200 : 32'h400);
      step();
      b.mem_rvld  = 1'b1;
      b.mem_rdata = 32'hA000 + 32'(g);
      @(negedge CLK);
      chk($sformatf("starve%0d.mem_en", g), 32'(b.mem_en), 32'h0);
      chk_rd($sformatf("starve%0d", g), ei, ei ? 32'hA000 + 32'(g) : 32'h0,
             !ei, !ei ? 32'hA000 + 32'(g) : 32'h0);
      step();
      b.mem_rvld = 1'b0;
    end

    // LSU write with IFU pending: IFU goes in the very next cycle
    b.lsu_mem_wen = 4'b0011;
    b.lsu_addr    = 32'h500;
    b.lsu_wdata   = 32'hBEEF;
    @(negedge CLK);
    chk_bus("wr", 1'b0, 1'b1, 1'b1, 4'b0011, 32'h500, 32'hBEEF);
    step();
    b.lsu_mem_en  = 1'b0;
    b.lsu_mem_wen = 4'b0000;
    @(negedge CLK);
    chk_bus("wr_next", 1'b1, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0);
    chk_rd("wr_next", 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    b.ifu_req   = 1'b0;
    b.mem_rvld  = 1'b1;
    b.mem_rdata = 32'h5151;
    @(negedge CLK);
    chk_rd("wr_ifu_ret", 1'b1, 32'h5151, 1'b0, 32'h0);
    step();
    idle_in();

    // Read that never returns: abandoned when wait_cnt reaches 15
    b.lsu_mem_en = 1'b1;
    b.lsu_addr   = 32'h600;
    @(negedge CLK);
    chk("to.lsu_gnt", 32'(b.lsu_gnt), 32'h1);
    step();
    idle_in();
    b.mem_rdata = 32'hFFFFFFFF;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      chk($sformatf("to%0d.lsu_rvld", k), 32'(b.lsu_mem_rvld), 32'(k == 16));
      chk($sformatf("to%0d.lsu_rdata", k), b.lsu_rdata, 32'h0);
      chk($sformatf("to%0d.err", k), 32'(b.err_timeout), 32'h0);
      step();
    end
    b.ifu_req  = 1'b1;
    b.ifu_addr = 32'h700;
    @(negedge CLK);
    chk("to_after.err", 32'(b.err_timeout), 32'h1);
    chk_bus("to_after", 1'b1, 1'b0, 1'b1, 4'h0, 32'h700, 32'h0);
    step();
    b.ifu_req   = 1'b0;
    b.mem_rvld  = 1'b1;
    b.mem_rdata = 32'h12345678;
    @(negedge CLK);
    chk_rd("to_ifu_ret", 1'b1, 32'h12345678, 1'b0, 32'h0);
    chk("to_ifu_ret.err", 32'(b.err_timeout), 32'h1);
    step();
    idle_in();

    // Reset in the middle of an LSU read
    b.lsu_mem_en = 1'b1;
    b.lsu_addr   = 32'h800;
    @(negedge CLK);
    chk("rst_rd.lsu_gnt", 32'(b.lsu_gnt), 32'h1);
    step();
    b.ifu_req = 1'b1;
    b.ifu_addr = 32'h900;
    #2;
    RSTN = 1'b0;
    b.mem_rvld  = 1'b1;
    b.mem_rdata = 32'hABCD;
    #1;
    chk_bus("rst_mid", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk_rd("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_mid.err", 32'(b.err_timeout), 32'h0);
    idle_in();
    @(negedge CLK);
    RSTN = 1'b1;
    step();
    b.mem_rvld  = 1'b1;
    b.mem_rdata = 32'hAB;
    @(negedge CLK);
    chk_rd("rst_late", 1'b0, 32'h0, 1'b0, 32'h0);
    chk_bus("rst_late", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst_late.err", 32'(b.err_timeout), 32'h0);
    step();
    b.mem_rvld = 1'b0;
    b.ifu_req  = 1'b1;
    b.ifu_addr = 32'hA00;
    @(negedge CLK);
    chk_bus("rst_regrant", 1'b1, 1'b0, 1'b1, 4'h0, 32'hA00, 32'h0);
    step();
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
